// File: rtl/inner_product.sv
// inner_product: pipelined signed 16-term Q1.7 dot product, requantized to Q1.7.
// Define INNER_PRODUCT_SAT_EN for a saturating output; otherwise the output wraps.
module inner_product (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] iW1,
  input  logic [7:0] iW2,
  input  logic [7:0] iW3,
  input  logic [7:0] iW4,
  input  logic [7:0] iW5,
  input  logic [7:0] iW6,
  input  logic [7:0] iW7,
  input  logic [7:0] iW8,
  input  logic [7:0] iW9,
  input  logic [7:0] iW10,
  input  logic [7:0] iW11,
  input  logic [7:0] iW12,
  input  logic [7:0] iW13,
  input  logic [7:0] iW14,
  input  logic [7:0] iW15,
  input  logic [7:0] iW16,
  input  logic [7:0] iX1,
  input  logic [7:0] iX2,
  input  logic [7:0] iX3,
  input  logic [7:0] iX4,
  input  logic [7:0] iX5,
  input  logic [7:0] iX6,
  input  logic [7:0] iX7,
  input  logic [7:0] iX8,
  input  logic [7:0] iX9,
  input  logic [7:0] iX10,
  input  logic [7:0] iX11,
  input  logic [7:0] iX12,
  input  logic [7:0] iX13,
  input  logic [7:0] iX14,
  input  logic [7:0] iX15,
  input  logic [7:0] iX16,
  output logic [7:0] oInnerout
);
  logic signed [7:0]  w_d [16];
  logic signed [7:0]  w_q [16];
  logic signed [7:0]  x_d [16];
  logic signed [7:0]  x_q [16];
  logic signed [15:0] prod_d [16];
  logic signed [15:0] prod_q [16];
  logic signed [17:0] psum_d [4];
  logic signed [17:0] psum_q [4];
  logic signed [19:0] acc;
  logic signed [12:0] q;
  logic [7:0]         out_d;
  logic [7:0]         out_q;
  logic               unused_bits;
  always_comb begin
    w_d = '{iW1, iW2, iW3, iW4, iW5, iW6, iW7, iW8, iW9, iW10, iW11, iW12, iW13, iW14, iW15, iW16};
    x_d = '{iX1, iX2, iX3, iX4, iX5, iX6, iX7, iX8, iX9, iX10, iX11, iX12, iX13, iX14, iX15, iX16};
    for (int i = 0; i < 16; i++) prod_d[i] = w_q[i] * x_q[i];
    for (int i = 0; i < 4; i++)
      psum_d[i] = 18'(prod_q[4*i]) + 18'(prod_q[4*i+1]) + 18'(prod_q[4*i+2]) + 18'(prod_q[4*i+3]);
    acc = 20'(psum_q[0]) + 20'(psum_q[1]) + 20'(psum_q[2]) + 20'(psum_q[3]);
    // Dropping the low 7 bits of a two's-complement value is a floor divide by 128.
    q = acc[19:7];
`ifdef INNER_PRODUCT_SAT_EN
    out_d = (q > 13'sd127) ? 8'h7f : (q < -13'sd128) ? 8'h80 : q[7:0];
    unused_bits = ^acc[6:0];
`else
    out_d = q[7:0];
    unused_bits = ^{acc[6:0], q[12:8]};
`endif
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      w_q    <= '{default: '0};
      x_q    <= '{default: '0};
      prod_q <= '{default: '0};
      psum_q <= '{default: '0};
      out_q  <= '0;
    end else begin
      w_q    <= w_d;
      x_q    <= x_d;
      prod_q <= prod_d;
      psum_q <= psum_d;
      out_q  <= out_d;
    end
  end
  assign oInnerout = out_q;
endmodule

// File: tb/tb_inner_product.sv
// tb_inner_product: directed and streaming checks of the inner_product pipeline.
module tb_inner_product;
  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [7:0] w [16];
  logic [7:0] x [16];
  logic [7:0] out;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  inner_product dut (
    .clk(clk), .resetn(resetn),
    .iW1(w[0]), .iW2(w[1]), .iW3(w[2]), .iW4(w[3]),
    .iW5(w[4]), .iW6(w[5]), .iW7(w[6]), .iW8(w[7]),
    .iW9(w[8]), .iW10(w[9]), .iW11(w[10]), .iW12(w[11]),
    .iW13(w[12]), .iW14(w[13]), .iW15(w[14]), .iW16(w[15]),
    .iX1(x[0]), .iX2(x[1]), .iX3(x[2]), .iX4(x[3]),
    .iX5(x[4]), .iX6(x[5]), .iX7(x[6]), .iX8(x[7]),
    .iX9(x[8]), .iX10(x[9]), .iX11(x[10]), .iX12(x[11]),
    .iX13(x[12]), .iX14(x[13]), .iX15(x[14]), .iX16(x[15]),
    .oInnerout(out)
  );

  function automatic logic [7:0] model();
    int s = 0;
    int q;
    for (int k = 0; k < 16; k++) begin
      int a = $signed(w[k]);
      int b = $signed(x[k]);
      s += a * b;
    end
    q = s >>> 7;
`ifdef INNER_PRODUCT_SAT_EN
    if (q > 127) q = 127;
    if (q < -128) q = -128;
`endif
    return 8'(q);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    for (int k = 0; k < 16; k++) begin w[k] = 8'h00; x[k] = 8'h00; end
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 16; k++) begin w[k] = 8'($urandom); x[k] = 8'($urandom); end
  endtask

  task automatic flush();
    zero_inputs();
    repeat (4) step();
  endtask

  task automatic load(input int wv [16], input int xv [16]);
    for (int k = 0; k < 16; k++) begin w[k] = 8'(wv[k]); x[k] = 8'(xv[k]); end
  endtask

  task automatic run_single(input string name, input logic [7:0] exp);
    logic [7:0] sw [16];
    logic [7:0] sx [16];
    sw = w; sx = x;
    flush();
    w = sw; x = sx;
    step();
    zero_inputs();
    step();
    step();
    checks++;
    if (out !== 8'h00) begin
      errors++;
      $display("FAIL %s_early: got %02h want 00", name, out);
    end
    step();
    checks++;
    if (out !== exp) begin
      errors++;
      $display("FAIL %s: got %02h want %02h", name, out, exp);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      step();
      checks++;
      if (out !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %02h want 00", i, out);
      end
    end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      checks++;
      if (out !== 8'h00) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %02h want 00", i, out);
      end
    end
  endtask

  task automatic test_mixed();
    int wv [16] = '{127, 30, 0, 17, -120, -30, -12, 87, 65, 13, 127, 127, -127, -127, -1, -1};
    int xv [16] = '{127, 127, 127, 127, 120, 1, 14, -56, -43, 87, 127, 127, -127, -127, -1, -1};
    load(wv, xv);
`ifdef INNER_PRODUCT_SAT_EN
    run_single("mixed", 8'h7f);
`else
    run_single("mixed", 8'hff);
`endif
  endtask

  task automatic test_single_term();
    zero_inputs(); w[0] = 8'd127; x[0] = 8'd127;
    run_single("single_126", 8'h7e);
    zero_inputs(); w[0] = 8'hff; x[0] = 8'd1;
    run_single("floor_neg1", 8'hff);
    zero_inputs(); w[0] = 8'h80; x[0] = 8'd127;
    run_single("min_times_max", 8'h81);
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 16; k++) begin w[k] = 8'h80; x[k] = 8'h80; end
`ifdef INNER_PRODUCT_SAT_EN
    run_single("all_min_sq", 8'h7f);
`else
    run_single("all_min_sq", 8'h00);
`endif
    for (int k = 0; k < 16; k++) begin w[k] = 8'h80; x[k] = 8'h7f; end
`ifdef INNER_PRODUCT_SAT_EN
    run_single("all_min_max", 8'h80);
`else
    run_single("all_min_max", 8'h10);
`endif
  endtask

  task automatic stream(input string name, input int rst_at);
    logic [7:0] vw [20][16];
    logic [7:0] vx [20][16];
    logic [7:0] e [20];
    logic [7:0] want;
    for (int c = 0; c < 20; c++) begin
      if (c % 5 == 2) zero_inputs(); else rand_inputs();
      vw[c] = w; vx[c] = x; e[c] = model();
    end
    flush();
    for (int c = 0; c < 23; c++) begin
      if (c < 20) begin w = vw[c]; x = vx[c]; end else zero_inputs();
      resetn = (c == rst_at);
      step();
      if (c < 3 || (rst_at >= 0 && c >= rst_at && c < rst_at + 4)) want = 8'h00;
      else want = e[c-3];
      checks++;
      if (out !== want) begin
        errors++;
        $display("FAIL %s[%0d]: got %02h want %02h", name, c, out, want);
      end
    end
    resetn = 1'b0;
  endtask

  task automatic test_back_to_back();
    stream("pipeline", -1);
  endtask

  task automatic test_mid_reset();
    stream("mid_reset", 8);
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_mixed();
    test_single_term();
    test_extremes();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
